// File: rtl/silent_pkg.sv
// Shared types, constants and the linear step rule for the silent stepper.
package silent_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Cycles from a target read address to the registered stepped output.
    localparam int PIPE_LATENCY = 2;

    // Move cur toward tgt by at most step; never overshoots the target.
    // Operands are zero-extended by the caller, so the result stays in
    // [min(cur,tgt), max(cur,tgt)].
    function automatic logic [31:0] step_linear(input logic [31:0] cur,
                                                input logic [31:0] tgt,
                                                input logic [31:0] step);
        logic signed [33:0] d;
        logic signed [33:0] mag;
        logic [31:0]        res;
        d   = $signed({2'b00, tgt}) - $signed({2'b00, cur});
        mag = (d < 0) ? -d : d;
        if (mag <= $signed({2'b00, step})) begin
            res = tgt;
        end else if (d < 0) begin
            res = cur - step;
        end else begin
            res = cur + step;
        end
        return res;
    endfunction

endpackage

// File: rtl/silent_step_calc.sv
// Combinational single-channel step.
// Build option: define SILENT_STEPPER_PHASE_WRAP_EN for shortest-arc phase
// stepping modulo CYCLE; otherwise linear stepping and CYCLE is ignored.
module silent_step_calc
    import silent_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    input  logic [15:0]      step,
    input  logic [WIDTH-1:0] cycle,
    output logic [WIDTH-1:0] new_val
);

`ifdef SILENT_STEPPER_PHASE_WRAP_EN
    logic signed [33:0] cur_s;
    logic signed [33:0] tgt_s;
    logic signed [33:0] cyc_s;
    logic signed [33:0] half_s;
    logic signed [33:0] step_s;
    logic signed [33:0] d_s;
    logic signed [33:0] mag_s;
    logic signed [33:0] r_s;
    logic               unused_calc_bits;

    // Shortest-arc step on the phase circle, result reduced into [0, CYCLE-1].
    always_comb begin
        cur_s  = 34'(cur);
        cyc_s  = 34'(cycle);
        step_s = 34'(step);
        half_s = cyc_s >>> 1;
        tgt_s  = (tgt >= cycle) ? '0 : 34'(tgt);
        d_s    = tgt_s - cur_s;
        if (d_s > half_s) begin
            d_s = d_s - cyc_s;
        end else if (d_s < -half_s) begin
            d_s = d_s + cyc_s;
        end
        mag_s = (d_s < 0) ? -d_s : d_s;
        if (mag_s <= step_s) begin
            r_s = cur_s + d_s;
        end else if (d_s < 0) begin
            r_s = cur_s - step_s;
        end else begin
            r_s = cur_s + step_s;
        end
        if (r_s < 0) begin
            r_s = r_s + cyc_s;
        end else if (r_s >= cyc_s) begin
            r_s = r_s - cyc_s;
        end
        if (cycle == '0) begin
            r_s = cur_s;
        end
        new_val = r_s[WIDTH-1:0];
    end

    assign unused_calc_bits = ^r_s[33:WIDTH];
`else
    logic [31:0] lin_res;
    logic        unused_calc_bits;

    assign lin_res          = step_linear(32'(cur), 32'(tgt), 32'(step));
    assign new_val          = lin_res[WIDTH-1:0];
    assign unused_calc_bits = ^{lin_res[31:WIDTH], cycle};
`endif

endmodule

// File: rtl/silent_stepper.sv
// Silent stepper: on each UPDATE strobe, sweeps all channels and moves each
// current value toward its target by at most STEP, streaming the results.
// Build option: SILENT_STEPPER_PHASE_WRAP_EN selects phase wrap mode in the
// step calculator.
module silent_stepper
    import silent_pkg::*;
#(
    parameter  int WIDTH = 13,
    parameter  int DEPTH = 249,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UPDATE,
    input  logic [15:0]      STEP,
    input  logic [WIDTH-1:0] CYCLE,
    output logic [AW-1:0]    TGT_ADDR,
    input  logic [WIDTH-1:0] TGT_DATA,
    output logic [AW-1:0]    OUT_ADDR,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVERRUN
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [15:0]      step_q, step_d;
    logic [WIDTH-1:0] cycle_q, cycle_d;
    logic             s1_valid_q, s1_valid_d;
    logic [AW-1:0]    s1_addr_q, s1_addr_d;
    logic [WIDTH-1:0] s1_tgt_q, s1_tgt_d;
    logic             out_valid_q, out_valid_d;
    logic [AW-1:0]    out_addr_q, out_addr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             start;

    logic [WIDTH-1:0] cur_q [DEPTH];
    logic [WIDTH-1:0] cur_rd;
    logic [WIDTH-1:0] new_val;

    assign cur_rd = cur_q[s1_addr_q];

    silent_step_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .cur     (cur_rd),
        .tgt     (s1_tgt_q),
        .step    (step_q),
        .cycle   (cycle_q),
        .new_val (new_val)
    );

    // Next-state, address sequencing and pipeline stage inputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        step_d      = step_q;
        cycle_d     = cycle_q;
        overrun_d   = 1'b0;
        start       = 1'b0;
        s1_valid_d  = (state_q == RUN);
        s1_addr_d   = addr_q;
        s1_tgt_d    = TGT_DATA;
        out_valid_d = s1_valid_q;
        out_addr_d  = s1_valid_q ? s1_addr_q : out_addr_q;
        out_data_d  = s1_valid_q ? new_val : out_data_q;
        done_d      = s1_valid_q && (s1_addr_q == LAST_ADDR);

        case (state_q)
            IDLE: begin
                if (UPDATE) begin
                    start = 1'b1;
                end
            end
            RUN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
                if (UPDATE) begin
                    overrun_d = 1'b1;
                end
            end
            DRAIN: begin
                // The last output is on the bus; a strobe now starts the next
                // sweep as BUSY would otherwise fall.
                if (done_q) begin
                    if (UPDATE) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (UPDATE) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            state_d = RUN;
            addr_d  = '0;
            step_d  = STEP;
            cycle_d = CYCLE;
        end
    end

    // Control and pipeline registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            step_q      <= '0;
            cycle_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_tgt_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            step_q      <= step_d;
            cycle_q     <= cycle_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_tgt_q    <= s1_tgt_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    // Current-value store, written alongside each registered output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                cur_q[i] <= '0;
            end
        end else if (s1_valid_q) begin
            cur_q[s1_addr_q] <= new_val;
        end
    end

    assign TGT_ADDR  = addr_q;
    assign OUT_ADDR  = out_addr_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_silent_stepper.sv
// Testbench for silent_stepper: randomized targets and steps checked against
// a behavioural per-channel model, plus directed cases for timing, overrun,
// mid-sweep reset, boundaries and (with SILENT_STEPPER_PHASE_WRAP_EN) wrap mode.
module tb_silent_stepper;

    localparam int WIDTH = 13;
    localparam int DEPTH = 249;
    localparam int AW    = $clog2(DEPTH);

    logic             CLK = 1'b0;
    logic             RST;
    logic             UPDATE;
    logic [15:0]      STEP;
    logic [WIDTH-1:0] CYCLE;
    logic [AW-1:0]    TGT_ADDR;
    logic [WIDTH-1:0] TGT_DATA;
    logic [AW-1:0]    OUT_ADDR;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_VALID;
    logic             BUSY;
    logic             DONE;
    logic             OVERRUN;

    logic [WIDTH-1:0] tgtMem [DEPTH];
    int               modelCur [DEPTH];
    int               vectors = 0;
    int               miscompares = 0;
    int               obsFirst;
    int               obsLast;

    silent_stepper dut (
        .CLK       (CLK),
        .RST       (RST),
        .UPDATE    (UPDATE),
        .STEP      (STEP),
        .CYCLE     (CYCLE),
        .TGT_ADDR  (TGT_ADDR),
        .TGT_DATA  (TGT_DATA),
        .OUT_ADDR  (OUT_ADDR),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OVERRUN   (OVERRUN)
    );

    always #5 CLK = ~CLK;

    assign TGT_DATA = tgtMem[TGT_ADDR];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference rule: move toward the target by at most step, either on a line
    // or around a circle of circumference cyc along the shorter way.
    function automatic int modelStep(input int cur, input int tgt, input int step, input int cyc);
        int diff;
        int mv;
        int r;
`ifdef SILENT_STEPPER_PHASE_WRAP_EN
        if (cyc == 0) return cur;
        if (tgt >= cyc) tgt = 0;
        diff = tgt - cur;
        if (diff > cyc / 2) diff -= cyc;
        else if (diff < -(cyc / 2)) diff += cyc;
        if (diff >= -step && diff <= step) mv = diff;
        else mv = (diff > 0) ? step : -step;
        r = (cur + mv) % cyc;
        if (r < 0) r += cyc;
        return r;
`else
        diff = tgt - cur;
        if (diff >= -step && diff <= step) return tgt;
        mv = (diff > 0) ? step : -step;
        r  = cur + mv;
        return r;
`endif
    endfunction

    function automatic int genCycle();
`ifdef SILENT_STEPPER_PHASE_WRAP_EN
        return 8191;
`else
        return int'($urandom_range(0, 8191));
`endif
    endfunction

    task automatic fillTargets(input int value);
        for (int i = 0; i < DEPTH; i++) tgtMem[i] = WIDTH'(value);
    endtask

    task automatic randomTargets();
        for (int i = 0; i < DEPTH; i++) tgtMem[i] = WIDTH'($urandom_range(0, 8191));
    endtask

    task automatic applyReset();
        RST    = 1'b1;
        UPDATE = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < DEPTH; i++) modelCur[i] = 0;
        @(negedge CLK);
    endtask

    // One sweep: strobe UPDATE at the current falling edge, then check every
    // cycle of the sweep. overrunAt / rstAt (-1 = off) inject a second strobe
    // or a reset after cycle k; chain leaves the bench on the DONE cycle so
    // the next call strobes exactly as BUSY falls.
    task automatic applyStimulus(input int step, input int cyc, input int overrunAt,
                                 input int rstAt, input bit chain);
        int expNext [DEPTH];
        int lastK;
        bit expValid;
        for (int i = 0; i < DEPTH; i++) expNext[i] = modelStep(modelCur[i], int'(tgtMem[i]), step, cyc);
        STEP   = 16'(step);
        CYCLE  = WIDTH'(cyc);
        UPDATE = 1'b1;
        @(negedge CLK);
        UPDATE = 1'b0;
        lastK  = chain ? DEPTH + 1 : DEPTH + 3;
        for (int k = 0; k <= lastK; k++) begin
            if (rstAt >= 0 && k == rstAt + 1) begin
                checkOutput("rst_out_valid", int'(OUT_VALID), 0);
                checkOutput("rst_done", int'(DONE), 0);
                checkOutput("rst_busy", int'(BUSY), 0);
                RST = 1'b0;
                for (int i = 0; i < DEPTH; i++) modelCur[i] = 0;
                @(negedge CLK);
                checkOutput("rst_out_valid_after", int'(OUT_VALID), 0);
                checkOutput("rst_done_after", int'(DONE), 0);
                return;
            end
            expValid = (k >= 2 && k <= DEPTH + 1);
            checkOutput("out_valid", int'(OUT_VALID), int'(expValid));
            checkOutput("done", int'(DONE), int'(k == DEPTH + 1));
            checkOutput("busy", int'(BUSY), int'(k <= DEPTH + 1));
            checkOutput("overrun", int'(OVERRUN), int'(overrunAt >= 0 && k == overrunAt + 1));
            if (k <= DEPTH + 1) checkOutput("tgt_addr", int'(TGT_ADDR), (k < DEPTH) ? k : DEPTH - 1);
            if (expValid) begin
                checkOutput("out_addr", int'(OUT_ADDR), k - 2);
                checkOutput("out_data", int'(OUT_DATA), expNext[k - 2]);
                if (k == 2) obsFirst = int'(OUT_DATA);
                if (k == DEPTH + 1) obsLast = int'(OUT_DATA);
            end
            UPDATE = (k == overrunAt) ? 1'b1 : 1'b0;
            if (k == overrunAt) STEP = STEP ^ 16'h0155;
            if (k == rstAt) RST = 1'b1;
            if (k < lastK) @(negedge CLK);
        end
        for (int i = 0; i < DEPTH; i++) modelCur[i] = expNext[i];
    endtask

    function automatic int pickStep();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 64));
            1:       return int'($urandom_range(0, 9000));
            2:       return 65535;
            default: return int'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        int expLin  [5];
`ifdef SILENT_STEPPER_PHASE_WRAP_EN
        int expWrap [4];
`endif
        expLin = '{300, 600, 900, 1000, 1000};
        RST    = 1'b1;
        UPDATE = 1'b0;
        STEP   = '0;
        CYCLE  = '0;
        fillTargets(0);
        repeat (3) @(negedge CLK);
        checkOutput("reset_out_valid", int'(OUT_VALID), 0);
        checkOutput("reset_busy", int'(BUSY), 0);
        checkOutput("reset_done", int'(DONE), 0);
        checkOutput("reset_overrun", int'(OVERRUN), 0);
        checkOutput("reset_out_addr", int'(OUT_ADDR), 0);
        checkOutput("reset_out_data", int'(OUT_DATA), 0);
        checkOutput("reset_tgt_addr", int'(TGT_ADDR), 0);
        applyReset();

        // Linear approach to a common target.
        fillTargets(1000);
        for (int n = 0; n < 5; n++) begin
            applyStimulus(300, genCycle(), -1, -1, 1'b0);
            checkOutput("lin_ch0", obsFirst, expLin[n]);
            checkOutput("lin_chlast", obsLast, expLin[n]);
        end

        // Strobe during a sweep is ignored and flagged.
        randomTargets();
        applyStimulus(pickStep(), genCycle(), 50, -1, 1'b0);

        // Back-to-back sweeps, each strobed as BUSY falls.
        randomTargets();
        applyStimulus(pickStep(), genCycle(), -1, -1, 1'b1);
        randomTargets();
        applyStimulus(pickStep(), genCycle(), -1, -1, 1'b1);
        applyStimulus(pickStep(), genCycle(), -1, -1, 1'b0);

        // Step extremes.
        randomTargets();
        applyStimulus(0, genCycle(), -1, -1, 1'b0);
        applyStimulus(65535, genCycle(), -1, -1, 1'b0);
`ifndef SILENT_STEPPER_PHASE_WRAP_EN
        fillTargets(8191);
        applyStimulus(65535, genCycle(), -1, -1, 1'b0);
        checkOutput("ceiling", obsLast, 8191);
        fillTargets(0);
        applyStimulus(8191, genCycle(), -1, -1, 1'b0);
        checkOutput("floor", obsLast, 0);
`endif

        // Reset while channel 100 is on the output bus, then restart from 0.
        randomTargets();
        applyStimulus(65535, genCycle(), -1, 102, 1'b0);
        applyStimulus(pickStep(), genCycle(), -1, -1, 1'b0);

        // Random sweeps.
        for (int n = 0; n < 6; n++) begin
            randomTargets();
            applyStimulus(pickStep(), genCycle(), -1, -1, 1'b0);
        end

`ifdef SILENT_STEPPER_PHASE_WRAP_EN
        // Shortest arc across the wrap point.
        expWrap = '{4050, 4, 54, 100};
        applyReset();
        fillTargets(4000);
        applyStimulus(65535, 4096, -1, -1, 1'b0);
        checkOutput("wrap_seed", obsFirst, 4000);
        fillTargets(100);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(50, 4096, -1, -1, 1'b0);
            checkOutput("wrap_arc", obsFirst, expWrap[n]);
        end
        applyReset();
        fillTargets(2048);
        applyStimulus(10, 4096, -1, -1, 1'b0);
        checkOutput("wrap_tie", obsFirst, 10);
        applyReset();
        fillTargets(3000);
        applyStimulus(65535, 2000, -1, -1, 1'b0);
        checkOutput("wrap_tgt_over", obsFirst, 0);
        randomTargets();
        applyStimulus(100, 0, -1, -1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
